// File: rtl/multi_freq_div.sv
`default_nettype none
// ============================================================================
// Module   : multi_freq_div
// Purpose  : NCH independent programmable clock dividers. Each channel divides
//            clk by its div register and produces a one-cycle tick per period
//            and a clock-like wave (mode 0 = toggle on tick, mode 1 = square
//            with high time floor(div/2)).
// Ports    : clk       - system clock, rising edge
//            reset     - synchronous, active-low reset
//            en        - global count enable (low freezes every channel)
//            sync_clr  - strobe restarting all channels in phase
//            cfg_we    - configuration write strobe
//            cfg_ch    - channel index of the write (>= NCH ignored)
//            cfg_div   - divisor to write (0 disables the channel)
//            cfg_mode  - mode to write (0 toggle, 1 square)
//            tick      - registered one-cycle pulse per channel period
//            wave      - registered waveform per channel
// Options  : MULTI_FREQ_DIV_SHADOW_EN - when defined, writes land in shadow
//            registers and are applied at the channel's next terminal count
//            (or at once if the channel is disabled / on sync_clr), without
//            restarting the channel.
// Revision : 1.0 - initial release
// ============================================================================
module multi_freq_div #(
  parameter int NCH      = 3,
  parameter int CW       = 26,
  parameter int DEF_DIV  = 20_000_000,
  parameter int DEF_MODE = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           sync_clr,
  input  logic           cfg_we,
  input  logic [2:0]     cfg_ch,
  input  logic [CW-1:0]  cfg_div,
  input  logic           cfg_mode,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] wave
);

  localparam logic [CW-1:0] C_DEF_DIV  = CW'(DEF_DIV);
  localparam logic          C_DEF_MODE = (DEF_MODE != 0);
  localparam logic [CW-1:0] C_ZERO     = '0;
  localparam logic [CW-1:0] C_ONE      = CW'(1);

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [CW-1:0] div_q, div_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          mode_q, mode_d;
      logic          tick_q, tick_d;
      logic          wave_q, wave_d;
      logic          w_sel;
      logic          w_tc;
`ifdef MULTI_FREQ_DIV_SHADOW_EN
      logic [CW-1:0] shd_div_q, shd_div_d;
      logic          shd_mode_q, shd_mode_d;
      logic          pend_q, pend_d;
`endif

      // Indices >= NCH never match any generated channel, so such writes drop.
      assign w_sel = cfg_we && (cfg_ch == 3'(gi));
      // Only meaningful when div_q >= 1, so div_q - 1 cannot wrap here.
      assign w_tc  = (cnt_q == (div_q - C_ONE));

      always_comb begin
        div_d  = div_q;
        mode_d = mode_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        wave_d = wave_q;
`ifdef MULTI_FREQ_DIV_SHADOW_EN
        shd_div_d  = shd_div_q;
        shd_mode_d = shd_mode_q;
        pend_d     = pend_q;

        if (sync_clr) begin
          cnt_d  = C_ZERO;
          wave_d = 1'b0;
          // A write in the same cycle wins over an older pending shadow.
          if (w_sel) begin
            div_d  = cfg_div;
            mode_d = cfg_mode;
            pend_d = 1'b0;
          end else if (pend_q) begin
            div_d  = shd_div_q;
            mode_d = shd_mode_q;
            pend_d = 1'b0;
          end
        end else if (div_q == C_ZERO) begin
          // Idle channel: nothing to glitch, so a write takes effect at once.
          cnt_d  = C_ZERO;
          wave_d = 1'b0;
          if (w_sel) begin
            div_d  = cfg_div;
            mode_d = cfg_mode;
          end
        end else begin
          if (w_sel) begin
            shd_div_d  = cfg_div;
            shd_mode_d = cfg_mode;
            pend_d     = 1'b1;
          end
          if (en) begin
            cnt_d  = w_tc ? C_ZERO : (cnt_q + C_ONE);
            tick_d = w_tc;
            if (mode_q)
              wave_d = (cnt_d < (div_q >> 1));
            else if (w_tc)
              wave_d = ~wave_q;
            // Retune on the period boundary; a write landing on that very
            // edge is forwarded so it is not delayed a whole period.
            if (w_tc && (w_sel || pend_q)) begin
              div_d  = w_sel ? cfg_div  : shd_div_q;
              mode_d = w_sel ? cfg_mode : shd_mode_q;
              pend_d = 1'b0;
            end
          end
        end
`else
        if (sync_clr) begin
          cnt_d  = C_ZERO;
          wave_d = 1'b0;
          if (w_sel) begin
            div_d  = cfg_div;
            mode_d = cfg_mode;
          end
        end else if (w_sel) begin
          div_d  = cfg_div;
          mode_d = cfg_mode;
          cnt_d  = C_ZERO;
          wave_d = 1'b0;
        end else if (div_q == C_ZERO) begin
          cnt_d  = C_ZERO;
          wave_d = 1'b0;
        end else if (en) begin
          cnt_d  = w_tc ? C_ZERO : (cnt_q + C_ONE);
          tick_d = w_tc;
          if (mode_q)
            wave_d = (cnt_d < (div_q >> 1));
          else if (w_tc)
            wave_d = ~wave_q;
        end
`endif
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          div_q  <= C_DEF_DIV;
          mode_q <= C_DEF_MODE;
          cnt_q  <= C_ZERO;
          tick_q <= 1'b0;
          wave_q <= 1'b0;
`ifdef MULTI_FREQ_DIV_SHADOW_EN
          shd_div_q  <= C_DEF_DIV;
          shd_mode_q <= C_DEF_MODE;
          pend_q     <= 1'b0;
`endif
        end else begin
          div_q  <= div_d;
          mode_q <= mode_d;
          cnt_q  <= cnt_d;
          tick_q <= tick_d;
          wave_q <= wave_d;
`ifdef MULTI_FREQ_DIV_SHADOW_EN
          shd_div_q  <= shd_div_d;
          shd_mode_q <= shd_mode_d;
          pend_q     <= pend_d;
`endif
        end
      end

      assign tick[gi] = tick_q;
      assign wave[gi] = wave_q;
    end
  endgenerate

endmodule
`default_nettype wire
